// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request at a time from the processor's
// memory stage, performs a single bus transfer with an optional timeout, and
// returns the formatted load result or an error status on a one-cycle done pulse.
//
// state   | meaning
// IDLE    | waiting for start; request inputs are classified on acceptance
// ACCESS  | memValid held high until memReady or the wait limit is reached
// RESPOND | done pulse cycle; error flags are valid here only
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] baseValue,
  input  logic [31:0] offset,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        done,
  output logic [31:0] loadData,
  output logic        misaligned,
  output logic        illegal,
  output logic        timeout,
  output logic        memValid,
  output logic        memWe,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  memWriteMask,
  input  logic        memReady,
  input  logic [31:0] memReadData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t      state;
  logic [1:0]  addr_lo;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [31:0] wait_count;

  logic [31:0] addr_c;
  logic        illegal_c;
  logic        misaligned_c;
  logic [31:0] wdata_c;
  logic [3:0]  mask_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  // Classify the incoming request and build its lane-replicated store data.
  // Illegal encodings suppress the misaligned flag so only one error is reported.
  always_comb begin
    addr_c       = baseValue + offset;
    illegal_c    = isStore ? (funct3 > 3'b010)
                           : ((funct3[1:0] == 2'b11) || (funct3 == 3'b110));
    misaligned_c = 1'b0;
    wdata_c      = storeData;
    mask_c       = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata_c = {4{storeData[7:0]}};
        mask_c  = 4'b0001 << addr_c[1:0];
      end
      2'b01: begin
        misaligned_c = addr_c[0];
        wdata_c      = {2{storeData[15:0]}};
        mask_c       = addr_c[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: misaligned_c = (addr_c[1:0] != 2'b00);
      default: ;
    endcase
    if (illegal_c) misaligned_c = 1'b0;
  end

  // Select the addressed byte/halfword of the read word and extend it.
  always_comb begin
    byte_sel = memReadData[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? memReadData[31:16] : memReadData[15:0];
    case (funct3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {24'h0, byte_sel};
      3'b101:  load_fmt = {16'h0, half_sel};
      default: load_fmt = memReadData;
    endcase
  end

  // Request sequencing, bus handshake, wait counting and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state        <= IDLE;
      addr_lo      <= 2'b00;
      funct3_q     <= 3'b000;
      store_q      <= 1'b0;
      wait_count   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      misaligned   <= 1'b0;
      illegal      <= 1'b0;
      timeout      <= 1'b0;
      memValid     <= 1'b0;
      memWe        <= 1'b0;
      loadData     <= '0;
      memAddress   <= '0;
      memWriteData <= '0;
      memWriteMask <= '0;
    end else begin
      case (state)
        IDLE: begin
          done       <= 1'b0;
          misaligned <= 1'b0;
          illegal    <= 1'b0;
          timeout    <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            addr_lo  <= addr_c[1:0];
            funct3_q <= funct3;
            store_q  <= isStore;
            if (illegal_c || misaligned_c) begin
              state      <= RESPOND;
              done       <= 1'b1;
              illegal    <= illegal_c;
              misaligned <= misaligned_c;
            end else begin
              state        <= ACCESS;
              wait_count   <= '0;
              memValid     <= 1'b1;
              memWe        <= isStore;
              memAddress   <= {addr_c[31:2], 2'b00};
              memWriteData <= wdata_c;
              memWriteMask <= isStore ? mask_c : 4'b0000;
            end
          end
        end
        ACCESS: begin
          if (memReady) begin
            state    <= RESPOND;
            done     <= 1'b1;
            memValid <= 1'b0;
            memWe    <= 1'b0;
            if (!store_q) loadData <= load_fmt;
          end else if ((TIMEOUT > 0) && (wait_count == 32'(TIMEOUT - 1))) begin
            state    <= RESPOND;
            done     <= 1'b1;
            timeout  <= 1'b1;
            memValid <= 1'b0;
            memWe    <= 1'b0;
          end else begin
            wait_count <= wait_count + 32'd1;
          end
        end
        RESPOND: begin
          state      <= IDLE;
          done       <= 1'b0;
          busy       <= 1'b0;
          misaligned <= 1'b0;
          illegal    <= 1'b0;
          timeout    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4). Each request pushes its
// expected completion onto a scoreboard queue; the entry is popped and
// compared when done is seen. Bus-side behaviour is checked every cycle.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic        isStore;
  logic [2:0]  funct3;
  logic [31:0] baseValue;
  logic [31:0] offset;
  logic [31:0] storeData;
  logic        busy;
  logic        done;
  logic [31:0] loadData;
  logic        misaligned;
  logic        illegal;
  logic        timeout;
  logic        memValid;
  logic        memWe;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [3:0]  memWriteMask;
  logic        memReady;
  logic [31:0] memReadData;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        ill;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  load_store_unit #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .isStore(isStore), .funct3(funct3),
    .baseValue(baseValue), .offset(offset), .storeData(storeData),
    .busy(busy), .done(done), .loadData(loadData), .misaligned(misaligned),
    .illegal(illegal), .timeout(timeout), .memValid(memValid), .memWe(memWe),
    .memAddress(memAddress), .memWriteData(memWriteData), .memWriteMask(memWriteMask),
    .memReady(memReady), .memReadData(memReadData)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge. rdelay = ACCESS cycles with
  // memReady=0 before it rises (-1: never). exp_valid=0 means no bus access.
  task automatic run_op(input string name, input logic st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int rdelay, input bit hold,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_mask, input int exp_lat, input int exp_valid,
                        input exp_t e);
    int   cyc = 0;
    int   valid_cycles = 0;
    bit   got = 0;
    exp_t x;
    start = 1'b1; isStore = st; funct3 = f3; baseValue = base; offset = off;
    storeData = sdata; memReady = 1'b0;
    sb.push_back(e);
    while (cyc < 40 && !got) begin
      @(negedge CLK);
      cyc++;
      if (!hold) start = 1'b0;
      check({name, ":busy"}, 32'(busy), 32'd1);
      if (memValid) begin
        valid_cycles++;
        check({name, ":addr"}, memAddress, exp_addr);
        check({name, ":we"}, 32'(memWe), 32'(st));
        check({name, ":mask"}, 32'(memWriteMask), 32'(exp_mask));
        if (st) check({name, ":wdata"}, memWriteData, exp_wdata);
        memReadData = rdata;
        memReady = (rdelay >= 0) && (valid_cycles == rdelay + 1);
      end else begin
        memReady = 1'b0;
      end
      if (done) begin
        got = 1;
        x = sb.pop_front();
        check({name, ":loadData"}, loadData, x.ld);
        check({name, ":misaligned"}, 32'(misaligned), 32'(x.mis));
        check({name, ":illegal"}, 32'(illegal), 32'(x.ill));
        check({name, ":timeout"}, 32'(timeout), 32'(x.tmo));
      end
    end
    check({name, ":done_seen"}, 32'(got), 32'd1);
    check({name, ":latency"}, 32'(cyc), 32'(exp_lat));
    check({name, ":valid_cycles"}, 32'(valid_cycles), 32'(exp_valid));
    @(negedge CLK);
    check({name, ":done_after"}, 32'(done), 32'd0);
    check({name, ":busy_after"}, 32'(busy), 32'd0);
    check({name, ":valid_after"}, 32'(memValid), 32'd0);
    start = 1'b0;
    memReady = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; start = 1'b0; isStore = 1'b0; funct3 = 3'b000;
    baseValue = '0; offset = '0; storeData = '0; memReady = 1'b0; memReadData = '0;
    repeat (3) @(negedge CLK);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:memValid", 32'(memValid), 32'd0);
    check("rst:memWe", 32'(memWe), 32'd0);
    check("rst:flags", {29'd0, misaligned, illegal, timeout}, 32'd0);
    check("rst:loadData", loadData, 32'd0);
    check("rst:memAddress", memAddress, 32'd0);
    check("rst:memWriteData", memWriteData, 32'd0);
    check("rst:memWriteMask", 32'(memWriteMask), 32'd0);

    // Released together with the first start: accepted on the first RESET=1 edge.
    RESET = 1'b1;
    run_op("lb", 1'b0, 3'b000, 32'h100, 32'd3, 32'h0, 32'h80FF_1234, 0, 1'b0,
           32'h100, 32'h0, 4'b0000, 2, 1, '{32'hFFFF_FF80, 1'b0, 1'b0, 1'b0});
    run_op("lhu", 1'b0, 3'b101, 32'h100, 32'd2, 32'h0, 32'h8001_0000, 0, 1'b0,
           32'h100, 32'h0, 4'b0000, 2, 1, '{32'h0000_8001, 1'b0, 1'b0, 1'b0});
    run_op("lh", 1'b0, 3'b001, 32'h100, 32'd2, 32'h0, 32'h8001_0000, 1, 1'b0,
           32'h100, 32'h0, 4'b0000, 3, 2, '{32'hFFFF_8001, 1'b0, 1'b0, 1'b0});
    // start held high through the done cycle must not launch a second request.
    run_op("sb", 1'b1, 3'b000, 32'h200, 32'd1, 32'h1234_56AB, 32'h0, 3, 1'b1,
           32'h200, 32'hABAB_ABAB, 4'b0010, 5, 4, '{32'hFFFF_8001, 1'b0, 1'b0, 1'b0});
    run_op("sh", 1'b1, 3'b001, 32'h200, 32'd2, 32'hCAFE_BEEF, 32'h0, 0, 1'b0,
           32'h200, 32'hBEEF_BEEF, 4'b1100, 2, 1, '{32'hFFFF_8001, 1'b0, 1'b0, 1'b0});
    run_op("sw", 1'b1, 3'b010, 32'h200, 32'd4, 32'hDEAD_BEEF, 32'h0, 0, 1'b0,
           32'h204, 32'hDEAD_BEEF, 4'b1111, 2, 1, '{32'hFFFF_8001, 1'b0, 1'b0, 1'b0});
    run_op("lw_mis", 1'b0, 3'b010, 32'h100, 32'd2, 32'h0, 32'h0, 0, 1'b0,
           32'h0, 32'h0, 4'b0000, 1, 0, '{32'hFFFF_8001, 1'b1, 1'b0, 1'b0});
    run_op("ld_ill", 1'b0, 3'b011, 32'h100, 32'd0, 32'h0, 32'h0, 0, 1'b0,
           32'h0, 32'h0, 4'b0000, 1, 0, '{32'hFFFF_8001, 1'b0, 1'b1, 1'b0});
    run_op("st_ill_mis", 1'b1, 3'b011, 32'h100, 32'd1, 32'h0, 32'h0, 0, 1'b0,
           32'h0, 32'h0, 4'b0000, 1, 0, '{32'hFFFF_8001, 1'b0, 1'b1, 1'b0});
    run_op("sh_mis", 1'b1, 3'b001, 32'h100, 32'd3, 32'h0, 32'h0, 0, 1'b0,
           32'h0, 32'h0, 4'b0000, 1, 0, '{32'hFFFF_8001, 1'b1, 1'b0, 1'b0});
    run_op("lw_tmo", 1'b0, 3'b010, 32'h100, 32'd0, 32'h0, 32'h5555_5555, -1, 1'b0,
           32'h100, 32'h0, 4'b0000, 5, 4, '{32'hFFFF_8001, 1'b0, 1'b0, 1'b1});
    run_op("lw_limit", 1'b0, 3'b010, 32'h100, 32'd0, 32'h0, 32'h1122_3344, 3, 1'b0,
           32'h100, 32'h0, 4'b0000, 5, 4, '{32'h1122_3344, 1'b0, 1'b0, 1'b0});
    run_op("lbu_wrap", 1'b0, 3'b100, 32'h10, 32'hFFFF_FFF4, 32'h0, 32'h0000_00F0, 0, 1'b0,
           32'h4, 32'h0, 4'b0000, 2, 1, '{32'h0000_00F0, 1'b0, 1'b0, 1'b0});

    // Reset in the second ACCESS cycle aborts the transfer.
    start = 1'b1; isStore = 1'b0; funct3 = 3'b010; baseValue = 32'h300; offset = 32'h0;
    memReady = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    check("abort:valid1", 32'(memValid), 32'd1);
    @(negedge CLK);
    check("abort:valid2", 32'(memValid), 32'd1);
    RESET = 1'b0;
    @(negedge CLK);
    check("abort:valid_off", 32'(memValid), 32'd0);
    check("abort:busy_off", 32'(busy), 32'd0);
    check("abort:loadData", loadData, 32'd0);
    check("abort:memAddress", memAddress, 32'd0);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("abort:no_done", 32'(done), 32'd0);
      check("abort:idle_valid", 32'(memValid), 32'd0);
    end
    run_op("post_rst", 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 32'h0BAD_F00D, 0, 1'b0,
           32'h300, 32'h0, 4'b0000, 2, 1, '{32'h0BAD_F00D, 1'b0, 1'b0, 1'b0});

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
